// File: rtl/mp_csa_accumulator.sv
// Carry-save accumulator (S,C) with chunk-serial carry-propagate resolve and optional final subtract.
// Latency: CLEAR/ACCUM 1 cycle; res_valid NCH+1 cycles after RESOLVE, 2*NCH+1 after RESOLVE_SUB.
// Backpressure: cmd_ready only in IDLE; result held stable in DONE until res_ready.
// Build option: define MP_CSA_FINAL_SUB_EN to build the SUB pass and difference register.
module mp_csa_accumulator #(
    parameter int WIDTH = 512,
    parameter int CHUNK = 104
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH+1:0] op_x,
    input  logic [WIDTH+1:0] op_y,
    input  logic [WIDTH-1:0] mod,
    output logic [1:0]       acc_lsb,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf
);

    localparam int VW  = WIDTH + 2;
    localparam int XW  = WIDTH + 4;
    localparam int NCH = (VW + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_ACCUM = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_SUB  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [VW-1:0] s_q, s_d;
    logic [VW-1:0] c_q, c_d;
    logic [VW-1:0] sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // ACCUM compressor: S + C + X + Y, then divide by 4 in carry-save form
    // ------------------------------------------------------------------
    logic [XW-1:0] s_e, c_e, x_e, y_e;
    logic [XW-1:0] s1, c1, s2, c2;
    logic          low_cy;
    logic [VW-1:0] a_v, b_v, cy_v;
    logic [VW-1:0] acc_s, acc_c;
    logic          unused_lo;

    // Two 3:2 layers form the 4:2 compressor; a third 3:2 layer folds in the
    // carry out of the two low bits that the divide-by-4 shifts away.
    always_comb begin
        s_e = '0;
        s_e[VW-1:0] = s_q;
        c_e = '0;
        c_e[VW-1:0] = c_q;
        x_e = '0;
        x_e[VW-1:0] = op_x;
        y_e = '0;
        y_e[VW-1:0] = op_y;
        s1 = s_e ^ c_e ^ x_e;
        c1 = ((s_e & c_e) | (s_e & x_e) | (c_e & x_e)) << 1;
        s2 = s1 ^ c1 ^ y_e;
        c2 = ((s1 & c1) | (s1 & y_e) | (c1 & y_e)) << 1;
        // c2[0] is always zero, so the low pair carries only when both bit 1s are set.
        low_cy = s2[1] & c2[1];
        a_v = s2[XW-1:2];
        b_v = c2[XW-1:2];
        cy_v = '0;
        cy_v[0] = low_cy;
        acc_s = a_v ^ b_v ^ cy_v;
        acc_c = ((a_v & b_v) | (a_v & cy_v) | (b_v & cy_v)) << 1;
    end

    assign unused_lo = s2[0] ^ c2[0];

    // ------------------------------------------------------------------
    // ADD pass: one CHUNK-wide slice of S + C per cycle
    // ------------------------------------------------------------------
    logic [PW-1:0]    s_pad, c_pad;
    logic [CHUNK-1:0] add_a, add_b, add_res;
    logic [CHUNK:0]   add_full;
    logic             add_cin;

    // Pick slice cnt_q of S and C and add it with the carry left by the previous slice.
    always_comb begin
        s_pad = '0;
        s_pad[VW-1:0] = s_q;
        c_pad = '0;
        c_pad[VW-1:0] = c_q;
        add_a = '0;
        add_b = '0;
        for (int j = 0; j < NCH; j++) begin
            if (cnt_q == CW'(j)) begin
                add_a = s_pad[j*CHUNK +: CHUNK];
                add_b = c_pad[j*CHUNK +: CHUNK];
            end
        end
        add_cin  = (cnt_q == '0) ? 1'b0 : carry_q;
        add_full = {1'b0, add_a} + {1'b0, add_b} + {{CHUNK{1'b0}}, add_cin};
        add_res  = add_full[CHUNK-1:0];
    end

`ifdef MP_CSA_FINAL_SUB_EN
    // ------------------------------------------------------------------
    // SUB pass: sum - mod, one slice per cycle with a rippled borrow
    // ------------------------------------------------------------------
    logic [VW-1:0]    diff_q, diff_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             borrow_q, borrow_d;
    logic             sub_q, sub_d;
    logic             use_diff_q, use_diff_d;
    logic [PW-1:0]    r_pad, m_pad;
    logic [CHUNK-1:0] sub_a, sub_b, sub_res;
    logic [CHUNK:0]   sub_full;
    logic             sub_bin;

    // Pick slice cnt_q of the resolved sum and the sampled modulus and subtract with borrow.
    always_comb begin
        r_pad = '0;
        r_pad[VW-1:0] = sum_q;
        m_pad = '0;
        m_pad[WIDTH-1:0] = mod_q;
        sub_a = '0;
        sub_b = '0;
        for (int j = 0; j < NCH; j++) begin
            if (cnt_q == CW'(j)) begin
                sub_a = r_pad[j*CHUNK +: CHUNK];
                sub_b = m_pad[j*CHUNK +: CHUNK];
            end
        end
        sub_bin  = (cnt_q == '0) ? 1'b0 : borrow_q;
        sub_full = {1'b0, sub_a} - {1'b0, sub_b} - {{CHUNK{1'b0}}, sub_bin};
        sub_res  = sub_full[CHUNK-1:0];
    end
`else
    logic unused_mod;
    assign unused_mod = ^mod;
`endif

    // Next-state, handshake outputs and datapath register updates.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
`ifdef MP_CSA_FINAL_SUB_EN
        diff_d     = diff_q;
        mod_d      = mod_q;
        borrow_d   = borrow_q;
        sub_d      = sub_q;
        use_diff_d = use_diff_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op == OP_CLEAR) begin
                        s_d = '0;
                        c_d = '0;
                    end else if (cmd_op == OP_ACCUM) begin
                        s_d = acc_s;
                        c_d = acc_c;
                    end else begin
                        state_d = ST_ADD;
                        cnt_d   = '0;
`ifdef MP_CSA_FINAL_SUB_EN
                        sub_d      = cmd_op[0];
                        mod_d      = mod;
                        use_diff_d = 1'b0;
`endif
                    end
                end
            end
            ST_ADD: begin
                for (int i = 0; i < VW; i++) begin
                    if (cnt_q == CW'(i / CHUNK)) begin
                        sum_d[i] = add_res[i % CHUNK];
                    end
                end
                carry_d = add_full[CHUNK];
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
`ifdef MP_CSA_FINAL_SUB_EN
                    if (sub_q) begin
                        state_d = ST_SUB;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef MP_CSA_FINAL_SUB_EN
            ST_SUB: begin
                for (int i = 0; i < VW; i++) begin
                    if (cnt_q == CW'(i / CHUNK)) begin
                        diff_d[i] = sub_res[i % CHUNK];
                    end
                end
                borrow_d = sub_full[CHUNK];
                if (cnt_q == LAST) begin
                    cnt_d      = '0;
                    use_diff_d = ~sub_full[CHUNK];
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef MP_CSA_FINAL_SUB_EN
            diff_q     <= '0;
            mod_q      <= '0;
            borrow_q   <= 1'b0;
            sub_q      <= 1'b0;
            use_diff_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef MP_CSA_FINAL_SUB_EN
            diff_q     <= diff_d;
            mod_q      <= mod_d;
            borrow_q   <= borrow_d;
            sub_q      <= sub_d;
            use_diff_q <= use_diff_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [VW-1:0] sel_res;

`ifdef MP_CSA_FINAL_SUB_EN
    assign sel_res = use_diff_q ? diff_q : sum_q;
`else
    assign sel_res = sum_q;
`endif

    assign res_data = sel_res[WIDTH-1:0];
    assign res_ovf  = |sel_res[VW-1:WIDTH];
    assign acc_lsb  = s_q[1:0] + c_q[1:0];

endmodule

// File: tb/tb_mp_csa_accumulator.sv
// Self-checking bench for mp_csa_accumulator at WIDTH=8, CHUNK=4 (NCH=3).
// Latency: checks cycle counts from command acceptance to res_valid.
// Backpressure: exercises res_ready hold-off in DONE.
module tb_mp_csa_accumulator;

    localparam int W   = 8;
    localparam int CH  = 4;
    localparam int NCH = (W + 2 + CH - 1) / CH;
`ifdef MP_CSA_FINAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           resetn;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [W+1:0]   op_x;
    logic [W+1:0]   op_y;
    logic [W-1:0]   mod;
    logic [1:0]     acc_lsb;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic           res_ovf;

    int total = 0;
    int bad   = 0;
    int model_v = 0;   // value represented by S+C, tracked arithmetically

    mp_csa_accumulator #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .op_x      (op_x),
        .op_y      (op_y),
        .mod       (mod),
        .acc_lsb   (acc_lsb),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    // Reference: resolved value, optionally reduced once by the modulus.
    function automatic int exp_res(input int v, input bit sub, input int m);
        if (SUB_EN && sub && v >= m) return v - m;
        return v;
    endfunction

    function automatic int exp_lat(input bit sub);
        return (SUB_EN && sub) ? 2 * NCH + 1 : NCH + 1;
    endfunction

    // Issue one command; returns at the falling edge after the accepting edge.
    task automatic do_cmd(input logic [1:0] op, input logic [W+1:0] x,
                          input logic [W+1:0] y, input logic [W-1:0] m);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        op_x      = x;
        op_y      = y;
        mod       = m;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic accum(input int x, input int y);
        do_cmd(2'b01, (W+2)'(x), (W+2)'(y), '0);
        model_v = (model_v + x + y) >> 2;
    endtask

    task automatic clear_acc();
        do_cmd(2'b00, '0, '0, '0);
        model_v = 0;
    endtask

    // Issue RESOLVE/RESOLVE_SUB, wait (bounded) for res_valid, capture, optionally consume.
    task automatic run_resolve(input bit sub, input logic [W-1:0] m, input int hold,
                               input bit consume, output int lat,
                               output logic [W-1:0] data, output logic ovf);
        int cyc;
        do_cmd(sub ? 2'b11 : 2'b10, '0, '0, m);
        cyc = 1;
        while (!res_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        lat  = res_valid ? cyc : -1;
        data = res_data;
        ovf  = res_ovf;
        if (consume) begin
            repeat (hold) @(negedge clk);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got %0b want 0", res_valid); end
        total++; if (res_data !== '0) begin bad++; $display("FAIL rst_res_data: got %0d want 0", res_data); end
        total++; if (res_ovf !== 1'b0) begin bad++; $display("FAIL rst_res_ovf: got %0b want 0", res_ovf); end
        total++; if (acc_lsb !== 2'b00) begin bad++; $display("FAIL rst_acc_lsb: got %0d want 0", acc_lsb); end
        resetn = 1'b1;
        model_v = 0;
    endtask

    task automatic test_accum_resolve();
        int lat; logic [W-1:0] d; logic o; int ev;
        clear_acc();
        accum(12, 8);
        total++; if (acc_lsb !== 2'(model_v)) begin bad++; $display("FAIL basic_acc_lsb: got %0d want %0d", acc_lsb, model_v % 4); end
        run_resolve(1'b0, '0, 0, 1'b1, lat, d, o);
        ev = exp_res(model_v, 1'b0, 0);
        total++; if (lat != NCH + 1) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, NCH + 1); end
        total++; if (d !== ev[W-1:0]) begin bad++; $display("FAIL basic_data: got %0d want %0d", d, ev % 256); end
        total++; if (o !== (ev >= 256)) begin bad++; $display("FAIL basic_ovf: got %0b want %0b", o, ev >= 256); end
    endtask

    task automatic test_overflow();
        int lat; logic [W-1:0] d; logic o; int ev;
        clear_acc();
        accum(1000, 200);
        run_resolve(1'b0, '0, 1, 1'b1, lat, d, o);
        ev = exp_res(model_v, 1'b0, 0);
        total++; if (d !== ev[W-1:0]) begin bad++; $display("FAIL ovf_data: got %0d want %0d", d, ev % 256); end
        total++; if (o !== (ev >= 256)) begin bad++; $display("FAIL ovf_flag: got %0b want %0b", o, ev >= 256); end
        run_resolve(1'b1, 8'd200, 0, 1'b1, lat, d, o);
        ev = exp_res(model_v, 1'b1, 200);
        total++; if (lat != exp_lat(1'b1)) begin bad++; $display("FAIL ovf_sub_latency: got %0d want %0d", lat, exp_lat(1'b1)); end
        total++; if (d !== ev[W-1:0]) begin bad++; $display("FAIL ovf_sub_data: got %0d want %0d", d, ev % 256); end
        total++; if (o !== (ev >= 256)) begin bad++; $display("FAIL ovf_sub_flag: got %0b want %0b", o, ev >= 256); end
    endtask

    task automatic test_sub();
        int lat; logic [W-1:0] d; logic o; int ev;
        int mods [3] = '{7, 5, 3};
        clear_acc();
        accum(20, 0);
        for (int k = 0; k < 3; k++) begin
            run_resolve(1'b1, W'(mods[k]), k, 1'b1, lat, d, o);
            ev = exp_res(model_v, 1'b1, mods[k]);
            total++; if (lat != exp_lat(1'b1)) begin bad++; $display("FAIL sub_latency m=%0d: got %0d want %0d", mods[k], lat, exp_lat(1'b1)); end
            total++; if (d !== ev[W-1:0]) begin bad++; $display("FAIL sub_data m=%0d: got %0d want %0d", mods[k], d, ev % 256); end
            total++; if (o !== 1'b0) begin bad++; $display("FAIL sub_ovf m=%0d: got %0b want 0", mods[k], o); end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [W-1:0] d; logic o; int ev;
        clear_acc();
        accum($urandom_range(300, 1023), $urandom_range(0, 1023));
        ev = exp_res(model_v, 1'b0, 0);
        run_resolve(1'b0, '0, 0, 1'b0, lat, d, o);
        total++; if (lat != NCH + 1) begin bad++; $display("FAIL bp_latency: got %0d want %0d", lat, NCH + 1); end
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'b01;
            op_x      = (W+2)'($urandom_range(1, 1023));
            op_y      = (W+2)'($urandom_range(1, 1023));
            @(negedge clk);
            total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c%0d: got %0b want 1", i, res_valid); end
            total++; if (res_data !== ev[W-1:0]) begin bad++; $display("FAIL bp_hold_data c%0d: got %0d want %0d", i, res_data, ev % 256); end
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_cmd_ready c%0d: got %0b want 0", i, cmd_ready); end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %0b want 1", cmd_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %0b want 0", res_valid); end
        total++; if (acc_lsb !== 2'(model_v)) begin bad++; $display("FAIL bp_ignored_cmd: got %0d want %0d", acc_lsb, model_v % 4); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [W-1:0] d; logic o; int x; int y;
        clear_acc();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
            cmd_valid = 1'b1;
            cmd_op    = 2'b01;
            op_x      = (W+2)'(x);
            op_y      = (W+2)'(y);
            @(negedge clk);
            model_v = (model_v + x + y) >> 2;
            total++; if (acc_lsb !== 2'(model_v)) begin bad++; $display("FAIL b2b_acc_lsb i%0d: got %0d want %0d", i, acc_lsb, model_v % 4); end
        end
        cmd_valid = 1'b0;
        run_resolve(1'b0, '0, 0, 1'b1, lat, d, o);
        total++; if (d !== 8'(model_v)) begin bad++; $display("FAIL b2b_data: got %0d want %0d", d, model_v % 256); end
        total++; if (o !== (model_v >= 256)) begin bad++; $display("FAIL b2b_ovf: got %0b want %0b", o, model_v >= 256); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [W-1:0] d; logic o;
        clear_acc();
        accum(1000, 200);
        do_cmd(2'b11, '0, '0, 8'd100);
        // Now in the first cycle after acceptance; four more edges land in SUB chunk 1.
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_v = 0;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", res_valid); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %0b want 1", cmd_ready); end
        total++; if (acc_lsb !== 2'b00) begin bad++; $display("FAIL midrst_acc_lsb: got %0d want 0", acc_lsb); end
        total++; if (res_data !== '0) begin bad++; $display("FAIL midrst_data: got %0d want 0", res_data); end
        accum(4, 0);
        total++; if (acc_lsb !== 2'(model_v)) begin bad++; $display("FAIL midrst_accum_lsb: got %0d want %0d", acc_lsb, model_v % 4); end
        run_resolve(1'b0, '0, 0, 1'b1, lat, d, o);
        total++; if (d !== 8'(model_v)) begin bad++; $display("FAIL midrst_resolve: got %0d want %0d", d, model_v); end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] d; logic o;
        int r; int x; int y; int m; int ev; bit sub;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                clear_acc();
                total++; if (acc_lsb !== 2'b00) begin bad++; $display("FAIL rnd_clear it%0d: got %0d want 0", it, acc_lsb); end
            end else if (r <= 5) begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
                accum(x, y);
                total++; if (acc_lsb !== 2'(model_v)) begin bad++; $display("FAIL rnd_acc_lsb it%0d: got %0d want %0d", it, acc_lsb, model_v % 4); end
            end else begin
                sub = (r >= 8);
                m = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : (model_v % 256);
                run_resolve(sub, W'(m), $urandom_range(0, 3), 1'b1, lat, d, o);
                ev = exp_res(model_v, sub, m);
                total++; if (lat != exp_lat(sub)) begin bad++; $display("FAIL rnd_latency it%0d: got %0d want %0d", it, lat, exp_lat(sub)); end
                total++; if (d !== ev[W-1:0]) begin bad++; $display("FAIL rnd_data it%0d v=%0d m=%0d sub=%0b: got %0d want %0d", it, model_v, m, sub, d, ev % 256); end
                total++; if (o !== (ev >= 256)) begin bad++; $display("FAIL rnd_ovf it%0d: got %0b want %0b", it, o, ev >= 256); end
            end
        end
    endtask

    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        op_x      = '0;
        op_y      = '0;
        mod       = '0;
        res_ready = 1'b0;
        test_reset();
        test_accum_resolve();
        test_overflow();
        test_sub();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/mp_csa_accumulator.md
MP_CSA_ACCUMULATOR -- requirements
Module: mp_csa_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 512, result width in bits (>= 8).
REQ-002 SHALL have parameter CHUNK, default 104, carry-propagate slice width (4 <= CHUNK <= WIDTH+2); NCH = ceil((WIDTH+2)/CHUNK).
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  2  00 CLEAR, 01 ACCUM, 10 RESOLVE, 11 RESOLVE_SUB.
- op_x  in  WIDTH+2  first ACCUM addend.
- op_y  in  WIDTH+2  second ACCUM addend.
- mod  in  WIDTH  modulus for RESOLVE_SUB; sampled at acceptance.
- acc_lsb  out  2  bits [1:0] of (S+C).
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when high with res_valid.
- res_data  out  WIDTH  resolved result, low WIDTH bits.
- res_ovf  out  1  selected result has any bit set at or above WIDTH.

Function
REQ-004 SHALL hold carry-save state S, C, each WIDTH+2 bits; represented value V = S+C.
REQ-005 SHALL assert cmd_ready only in state IDLE; a command is taken on the edge where cmd_valid && cmd_ready.
REQ-006 CLEAR SHALL set S = C = 0 on that edge; FSM stays IDLE.
REQ-007 ACCUM SHALL compute T = S+C+op_x+op_y with a 4:2 carry-save compressor (no full-width carry chain), internally WIDTH+4 bits, then load S,C so that S+C = T[WIDTH+3:2]; 1-cycle latency, FSM stays IDLE.
REQ-008 acc_lsb SHALL be combinational from the S,C registers and valid in every cycle.
REQ-009 RESOLVE SHALL enter ADD and process chunk k = 0..NCH-1 in successive cycles: (S+C) slice k plus a registered carry, written to a WIDTH+2-bit result register; carry SHALL be cleared at chunk 0.
REQ-010 After ADD chunk NCH-1, RESOLVE SHALL go to DONE; RESOLVE_SUB SHALL go to SUB (REQ-011).
REQ-011 SUB SHALL compute sum - {2'b00,mod} chunk-wise over NCH cycles with a registered borrow into a separate difference register; on exit, final borrow = 0 selects the difference, else the sum; then DONE.
REQ-012 In DONE, res_valid SHALL be high and res_data/res_ovf SHALL be stable; on res_valid && res_ready go to IDLE next cycle.
REQ-013 Latency from the acceptance edge: res_valid is first high NCH+1 cycles later for RESOLVE, 2*NCH+1 cycles later for RESOLVE_SUB.
REQ-014 S and C SHALL be unchanged by RESOLVE/RESOLVE_SUB, so ACCUM may continue after a result.
REQ-015 The chunk counter SHALL wrap to 0 on leaving ADD or SUB; the final chunk is partial when CHUNK does not divide WIDTH+2, with upper bits zero-extended.
REQ-016 Overflow beyond WIDTH+4 bits in ACCUM SHALL be silently discarded; keeping V < 2^(WIDTH+2) is the caller's responsibility.

Reset
REQ-017 When resetn = 0 at an edge, S, C, result, difference, carry/borrow and counter SHALL clear and the FSM SHALL go to IDLE, including mid-ADD, mid-SUB or in DONE.
REQ-018 Outputs after reset SHALL be: cmd_ready = 1, res_valid = 0, res_data = 0, res_ovf = 0, acc_lsb = 0.

Configuration
REQ-019 With macro MP_CSA_FINAL_SUB_EN defined, SUB and the difference register SHALL be built; undefined, cmd_op 11 SHALL behave exactly as 10 and SUB logic SHALL be absent.

Verification (WIDTH=8, CHUNK=4, NCH=3)
REQ-020 Reset: after resetn low 2 cycles -> cmd_ready=1, res_valid=0, res_data=0, acc_lsb=0.
REQ-021 CLEAR, ACCUM x=12 y=8, RESOLVE accepted at T -> res_valid first high at T+4, res_data=5, res_ovf=0.
REQ-022 CLEAR, ACCUM x=1000 y=200, RESOLVE -> res_data=44, res_ovf=1; RESOLVE_SUB mod=200 (macro on) -> res_data=100, res_ovf=0, valid at T+7.
REQ-023 V=5, RESOLVE_SUB mod=7 -> res_data=5 (borrow); mod=5 -> res_data=0; macro off: mod=3 -> res_data=5 at T+4.
REQ-024 Backpressure: res_ready low 5 cycles in DONE -> res_valid and res_data held, cmd_ready=0, cmd_valid ignored; res_ready high -> cmd_ready=1 next cycle.
REQ-025 resetn low during SUB chunk 1 -> next cycle IDLE, res_valid=0, S=C=0; a following ACCUM x=4 y=0 gives acc_lsb=1.
